// File: rtl/hps_io_pkg.sv
// Shared types and gp_out bit positions for the HPS I/O framer.
package hps_io_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CMD = 2'd1,
    PAYLOAD  = 2'd2
  } state_t;

  localparam int GP_FPGA_EN  = 18;
  localparam int GP_IO_EN    = 20;
  localparam int GP_WORD_MSB = 15;

endpackage

// File: rtl/hps_io_framer.sv
// Frames io_enable-bracketed HPS transactions into a command word plus indexed
// payload words, and returns the handler response (or core id) on gp_in.
module hps_io_framer
  import hps_io_pkg::*;
#(
  parameter int          IDX_W   = 12,
  parameter logic [15:0] CORE_ID = 16'h4D58
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic [31:0]      gp_out,
  input  logic             io_strobe,
  output logic [15:0]      gp_in,
  input  logic [15:0]      resp_word,
  output logic [15:0]      cmd,
  output logic             cmd_valid,
  output logic [15:0]      data_word,
  output logic             data_valid,
  output logic [IDX_W-1:0] word_index,
  output logic             frame_active,
  output logic             frame_end,
  output logic [IDX_W-1:0] frame_len,
  output logic             overflow
);

  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  state_t           state, next_state;
  logic             en;
  logic [15:0]      word;
  logic [IDX_W-1:0] count;
  logic             accept_cmd, accept_data, close_frame;
  logic             unused_gp_bits;

  assign en   = gp_out[GP_FPGA_EN] & gp_out[GP_IO_EN];
  assign word = gp_out[GP_WORD_MSB:0];
  assign unused_gp_bits = ^{gp_out[31:21], gp_out[19], gp_out[17:16]};

  always_ff @(posedge sys_clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Dropping enable always wins over a coincident strobe, so that word is lost.
  always_comb begin
    next_state  = state;
    accept_cmd  = 1'b0;
    accept_data = 1'b0;
    close_frame = 1'b0;
    case (state)
      IDLE: begin
        if (en) next_state = WAIT_CMD;
      end
      WAIT_CMD: begin
        if (!en) begin
          next_state = IDLE;
        end else if (io_strobe) begin
          accept_cmd = 1'b1;
          next_state = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!en) begin
          close_frame = 1'b1;
          next_state  = IDLE;
        end else if (io_strobe) begin
          accept_data = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      cmd          <= '0;
      cmd_valid    <= 1'b0;
      data_word    <= '0;
      data_valid   <= 1'b0;
      word_index   <= '0;
      frame_active <= 1'b0;
      frame_end    <= 1'b0;
      frame_len    <= '0;
      overflow     <= 1'b0;
      count        <= '0;
      gp_in        <= CORE_ID;
    end else begin
      cmd_valid  <= 1'b0;
      data_valid <= 1'b0;
      frame_end  <= 1'b0;
      gp_in      <= (state == PAYLOAD) ? resp_word : CORE_ID;

      if (accept_cmd) begin
        cmd          <= word;
        cmd_valid    <= 1'b1;
        word_index   <= '0;
        count        <= '0;
        overflow     <= 1'b0;
        frame_active <= 1'b1;
      end

      // At saturation the word is still delivered, at the held max index.
      if (accept_data) begin
        data_word  <= word;
        data_valid <= 1'b1;
        word_index <= count;
        if (count == IDX_MAX) overflow <= 1'b1;
        else                  count    <= count + 1'b1;
      end

      if (close_frame) begin
        frame_end    <= 1'b1;
        frame_len    <= count;
        frame_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hps_io_framer.sv
// Directed self-checking bench; a second instance with IDX_W=2 covers saturation.
module tb_hps_io_framer;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic [31:0] gp_out;
  logic        io_strobe;
  logic [15:0] resp_word;

  logic [15:0] gp_in_a, cmd_a, data_word_a;
  logic        cmd_valid_a, data_valid_a, frame_active_a, frame_end_a, overflow_a;
  logic [11:0] word_index_a, frame_len_a;

  logic [15:0] gp_in_b, cmd_b, data_word_b;
  logic        cmd_valid_b, data_valid_b, frame_active_b, frame_end_b, overflow_b;
  logic [1:0]  word_index_b, frame_len_b;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 sys_clk = ~sys_clk;

  hps_io_framer #(.IDX_W(12), .CORE_ID(16'h4D58)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .gp_out(gp_out), .io_strobe(io_strobe),
    .gp_in(gp_in_a), .resp_word(resp_word), .cmd(cmd_a), .cmd_valid(cmd_valid_a),
    .data_word(data_word_a), .data_valid(data_valid_a), .word_index(word_index_a),
    .frame_active(frame_active_a), .frame_end(frame_end_a), .frame_len(frame_len_a),
    .overflow(overflow_a)
  );

  hps_io_framer #(.IDX_W(2), .CORE_ID(16'h4D58)) dutSmall (
    .sys_clk(sys_clk), .reset_n(reset_n), .gp_out(gp_out), .io_strobe(io_strobe),
    .gp_in(gp_in_b), .resp_word(resp_word), .cmd(cmd_b), .cmd_valid(cmd_valid_b),
    .data_word(data_word_b), .data_valid(data_valid_b), .word_index(word_index_b),
    .frame_active(frame_active_b), .frame_end(frame_end_b), .frame_len(frame_len_b),
    .overflow(overflow_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, then lets one rising edge consume them.
  task automatic applyStimulus(input logic fpgaEn, input logic ioEn,
                               input logic strobe, input logic [15:0] word);
    gp_out    = {11'b0, ioEn, 1'b0, fpgaEn, 2'b0, word};
    io_strobe = strobe;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".cmd"},          32'(cmd_a),          32'h0);
    checkOutput({tag, ".cmd_valid"},    32'(cmd_valid_a),    32'h0);
    checkOutput({tag, ".data_word"},    32'(data_word_a),    32'h0);
    checkOutput({tag, ".data_valid"},   32'(data_valid_a),   32'h0);
    checkOutput({tag, ".word_index"},   32'(word_index_a),   32'h0);
    checkOutput({tag, ".frame_active"}, 32'(frame_active_a), 32'h0);
    checkOutput({tag, ".frame_end"},    32'(frame_end_a),    32'h0);
    checkOutput({tag, ".frame_len"},    32'(frame_len_a),    32'h0);
    checkOutput({tag, ".overflow"},     32'(overflow_a),     32'h0);
    checkOutput({tag, ".gp_in"},        32'(gp_in_a),        32'h4D58);
  endtask

  initial begin
    reset_n   = 1'b0;
    resp_word = 16'h0000;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkResetValues("reset");
    reset_n = 1'b1;

    // Basic frame: cmd 0x0014, two payload words.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0014);
    checkOutput("f1.cmd_valid",    32'(cmd_valid_a),    32'h1);
    checkOutput("f1.cmd",          32'(cmd_a),          32'h0014);
    checkOutput("f1.frame_active", 32'(frame_active_a), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hAAAA);
    checkOutput("f1.cmd_valid_drop", 32'(cmd_valid_a),  32'h0);
    checkOutput("f1.dv0",          32'(data_valid_a),   32'h1);
    checkOutput("f1.word0",        32'(data_word_a),    32'hAAAA);
    checkOutput("f1.idx0",         32'(word_index_a),   32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    checkOutput("f1.dv_gap",       32'(data_valid_a),   32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h5555);
    checkOutput("f1.dv1",          32'(data_valid_a),   32'h1);
    checkOutput("f1.word1",        32'(data_word_a),    32'h5555);
    checkOutput("f1.idx1",         32'(word_index_a),   32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("f1.frame_end",    32'(frame_end_a),    32'h1);
    checkOutput("f1.frame_len",    32'(frame_len_a),    32'h2);
    checkOutput("f1.active_off",   32'(frame_active_a), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("f1.frame_end_1cyc", 32'(frame_end_a),  32'h0);
    checkOutput("f1.len_hold",     32'(frame_len_a),    32'h2);
    checkOutput("f1.data_hold",    32'(data_word_a),    32'h5555);

    // Enable without a command, and a strobe seen in IDLE, produce nothing.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h7777);
    checkOutput("e2.idle_strobe",  32'(cmd_valid_a),    32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("e2.cmd_valid",    32'(cmd_valid_a),    32'h0);
    checkOutput("e2.frame_end",    32'(frame_end_a),    32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("e2.frame_end2",   32'(frame_end_a),    32'h0);
    checkOutput("e2.gp_in",        32'(gp_in_a),        32'h4D58);
    checkOutput("e2.cmd_hold",     32'(cmd_a),          32'h0014);

    // Five payload words: the IDX_W=2 instance saturates at index 3.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0099);
    checkOutput("s3.overflow_clr", 32'(overflow_b),     32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h1000 + 16'(i));
      checkOutput($sformatf("s3.dv%0d", i),  32'(data_valid_b), 32'h1);
      checkOutput($sformatf("s3.idx%0d", i), 32'(word_index_b), (i < 3) ? 32'(i) : 32'h3);
      checkOutput($sformatf("s3.ovf%0d", i), 32'(overflow_b),   (i < 3) ? 32'h0 : 32'h1);
      checkOutput($sformatf("s3.wideidx%0d", i), 32'(word_index_a), 32'(i));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("s3.frame_end",    32'(frame_end_b),    32'h1);
    checkOutput("s3.frame_len",    32'(frame_len_b),    32'h3);
    checkOutput("s3.ovf_sticky",   32'(overflow_b),     32'h1);
    checkOutput("s3.wide_len",     32'(frame_len_a),    32'h5);
    checkOutput("s3.wide_ovf",     32'(overflow_a),     32'h0);

    // Strobe while fpga_enable drops: word dropped, frame closes.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0021);
    checkOutput("d4.ovf_reset",    32'(overflow_b),     32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h3333);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hBEEF);
    checkOutput("d4.no_dv",        32'(data_valid_a),   32'h0);
    checkOutput("d4.frame_end",    32'(frame_end_a),    32'h1);
    checkOutput("d4.frame_len",    32'(frame_len_a),    32'h1);
    checkOutput("d4.word_kept",    32'(data_word_a),    32'h3333);

    // gp_in follows resp_word only while in PAYLOAD, one cycle late.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0042);
    checkOutput("r5.gp_in_cmd",    32'(gp_in_a),        32'h4D58);
    resp_word = 16'h1234;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    checkOutput("r5.gp_in_resp",   32'(gp_in_a),        32'h1234);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("r5.gp_in_close",  32'(gp_in_a),        32'h1234);
    checkOutput("r5.frame_end",    32'(frame_end_a),    32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("r5.gp_in_idle",   32'(gp_in_a),        32'h4D58);

    // Reset mid-frame at payload index 1, then a clean restart.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0055);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hA001);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hA002);
    checkOutput("m6.idx1",         32'(word_index_a),   32'h1);
    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    checkResetValues("m6.reset");
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    checkOutput("m6.no_frame_end", 32'(frame_end_a),    32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h00C3);
    checkOutput("m6.cmd_valid",    32'(cmd_valid_a),    32'h1);
    checkOutput("m6.cmd",          32'(cmd_a),          32'h00C3);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hD00D);
    checkOutput("m6.idx0",         32'(word_index_a),   32'h0);
    checkOutput("m6.word0",        32'(data_word_a),    32'hD00D);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("m6.frame_len",    32'(frame_len_a),    32'h1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Pulses must never overlap.
  always @(negedge sys_clk) begin
    if (reset_n && cmd_valid_a && data_valid_a) begin
      testsFailed++;
      $display("[TB] FAIL pulse_overlap: cmd_valid=1 data_valid=1, expected not both");
    end
  end

endmodule
